// File: rtl/aes128_package.sv
// Shared types and combinational GF(2^4) helpers for the tower-field S-box
// datapath.
//
// Representation:
//   GF(2^2) normal basis (W^2, W), with W^2 + W + 1 = 0. The identity is 2'b11.
//   GF(2^4) normal basis (Z^4, Z) over GF(2^2), with Z^2 + Z + N = 0, N = W^2.
//   The identity is 4'hF.
//   GF(2^8) normal basis (Y^16, Y) over GF(2^4), with Y^2 + Y + nu = 0,
//   nu = N^2 * Z. The identity is 8'hFF.
//
// In every packed element the high half holds the coefficient of the
// "conjugate" basis vector (W^2, Z^4 or Y^16).
package aes128_package;

  typedef logic [7:0] bv8_t;
  typedef logic [3:0] bv4_t;
  typedef logic [1:0] bv2_t;

  // Divider schedule: one bv4_mul product per state from S_D to S_M.
  typedef enum logic [2:0] {
    IDLE,
    S_D,
    S_I1,
    S_I0,
    S_H,
    S_L,
    S_M,
    S_OUT
  } bv8_div_state_t;

  // GF(2^2) multiply in the (W^2, W) normal basis.
  function automatic bv2_t bv2_mul(input bv2_t x, input bv2_t y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  // Squaring in a normal basis is a coefficient swap.
  function automatic bv2_t bv2_sq(input bv2_t x);
    return {x[0], x[1]};
  endfunction

  // Multiply by N = W^2.
  function automatic bv2_t bv2_scl_n(input bv2_t x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  // Multiply by N^2 = W.
  function automatic bv2_t bv2_scl_n2(input bv2_t x);
    return {x[1] ^ x[0], x[1]};
  endfunction

  // nu * x^2 in GF(2^4). Used for the GF(2^8) norm.
  function automatic bv4_t bv4_sq_scl_nu(input bv4_t x);
    bv2_t hi;
    bv2_t lo;
    hi = x[3:2];
    lo = x[1:0];
    return {bv2_sq(hi ^ lo), bv2_scl_n2(bv2_sq(lo))};
  endfunction

  // nu * x in GF(2^4).
  // Multiplying (P, Q) by nu gives (P ^ Q, P ^ N*Q).
  function automatic bv4_t bv4_scl_nu(input bv4_t x);
    bv2_t hi;
    bv2_t lo;
    hi = x[3:2];
    lo = x[1:0];
    return {hi ^ lo, hi ^ bv2_scl_n(lo)};
  endfunction

  // GF(2^4) inverse via the GF(2^2) norm. In GF(2^2) the inverse is the
  // square. The function maps 0 to 0.
  function automatic bv4_t bv4_inv(input bv4_t x);
    bv2_t hi;
    bv2_t lo;
    bv2_t nrm;
    bv2_t ninv;
    hi   = x[3:2];
    lo   = x[1:0];
    nrm  = bv2_scl_n(bv2_sq(hi ^ lo)) ^ bv2_mul(hi, lo);
    ninv = bv2_sq(nrm);
    return {bv2_mul(ninv, lo), bv2_mul(ninv, hi)};
  endfunction

endpackage

// File: rtl/bv4_mul.sv
// Combinational GF(2^4) multiplier in the (Z^4, Z) normal basis over GF(2^2).
//
// Ports:
//   x_i  [3:0]  first operand
//   y_i  [3:0]  second operand
//   p_o  [3:0]  product x_i * y_i
module bv4_mul
  import aes128_package::*;
(
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  output logic [3:0] p_o
);

  bv2_t e;

  // The cross term N*(x1^x0)*(y1^y0) is shared by both output halves.
  assign e   = bv2_scl_n(bv2_mul(x_i[3:2] ^ x_i[1:0], y_i[3:2] ^ y_i[1:0]));
  assign p_o = {bv2_mul(x_i[3:2], y_i[3:2]) ^ e,
                bv2_mul(x_i[1:0], y_i[1:0]) ^ e};

endmodule

// File: rtl/bv8_div_seq.sv
// Sequential GF(2^8) divider, c = a * b^-1, in the tower-field normal basis.
// A single bv4_mul is time-shared over six schedule states. The states are
// S_D, S_I1, S_I0, S_H, S_L and S_M. The result is then held in S_OUT until
// the consumer takes it.
//
// Parameters:
//   SKIP_ZERO     when set, a zero dividend or divisor jumps straight to S_OUT.
//
// Ports:
//   in_clock      clock, rising edge
//   in_reset      synchronous active-high reset
//   in_valid      operands valid (accepted when out_ready is high)
//   out_ready     idle, able to accept operands
//   in_a [7:0]    dividend {Y^16 coeff, Y coeff}
//   in_b [7:0]    divisor, same layout
//   out_valid     quotient valid
//   in_ready      consumer accepts quotient
//   out_c [7:0]   quotient
//   out_div_zero  divisor was zero (qualified by out_valid)
module bv8_div_seq
  import aes128_package::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_valid,
  output logic       out_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       in_ready,
  output logic [7:0] out_c,
  output logic       out_div_zero
);

  bv8_div_state_t state_q, state_d;

  bv8_t a_q, a_d;
  bv8_t b_q, b_d;
  bv8_t c_q, c_d;
  bv4_t dinv_q, dinv_d;
  bv4_t i1_q, i1_d;
  bv4_t i0_q, i0_d;
  bv4_t h_q, h_d;
  bv4_t l_q, l_d;
  logic a_zero_q, a_zero_d;
  logic b_zero_q, b_zero_d;
  logic valid_q, valid_d;
  logic ready_q, ready_d;

  bv4_t mul_x;
  bv4_t mul_y;
  bv4_t mul_p;
  bv4_t e_w;
  logic accept;
  logic in_a_zero;
  logic in_b_zero;

  assign in_a_zero = (in_a == 8'h00);
  assign in_b_zero = (in_b == 8'h00);
  assign accept    = in_valid && (state_q == IDLE);

  // Multiplier operands depend only on the state.
  // In IDLE and S_OUT they are parked at zero, so the multiplier does not
  // toggle while no operation is in flight.
  always_comb begin
    mul_x = 4'h0;
    mul_y = 4'h0;
    case (state_q)
      S_D: begin
        mul_x = b_q[7:4];
        mul_y = b_q[3:0];
      end
      S_I1: begin
        mul_x = dinv_q;
        mul_y = b_q[3:0];
      end
      S_I0: begin
        mul_x = dinv_q;
        mul_y = b_q[7:4];
      end
      S_H: begin
        mul_x = a_q[7:4];
        mul_y = i1_q;
      end
      S_L: begin
        mul_x = a_q[3:0];
        mul_y = i0_q;
      end
      S_M: begin
        mul_x = a_q[7:4] ^ a_q[3:0];
        mul_y = i1_q ^ i0_q;
      end
      default: begin
        mul_x = 4'h0;
        mul_y = 4'h0;
      end
    endcase
  end

  bv4_mul u_bv4_mul (
    .x_i (mul_x),
    .y_i (mul_y),
    .p_o (mul_p)
  );

  // Shared cross term of the final GF(2^8) product. It is only consumed in S_M.
  assign e_w = bv4_scl_nu(mul_p);

  // Next-state logic and datapath updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    dinv_d   = dinv_q;
    i1_d     = i1_q;
    i0_d     = i0_q;
    h_d      = h_q;
    l_d      = l_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = in_a;
          b_d      = in_b;
          a_zero_d = in_a_zero;
          b_zero_d = in_b_zero;
          if (SKIP_ZERO && (in_a_zero || in_b_zero)) begin
            c_d     = 8'h00;
            state_d = S_OUT;
          end else begin
            state_d = S_D;
          end
        end
      end
      S_D: begin
        // The norm of b is b1*b0 ^ nu*(b1^b0)^2. It lies in GF(2^4), and its
        // inverse scales the conjugate (b0, b1) into b^-1.
        dinv_d  = bv4_inv(mul_p ^ bv4_sq_scl_nu(b_q[7:4] ^ b_q[3:0]));
        state_d = S_I1;
      end
      S_I1: begin
        i1_d    = mul_p;
        state_d = S_I0;
      end
      S_I0: begin
        i0_d    = mul_p;
        state_d = S_H;
      end
      S_H: begin
        h_d     = mul_p;
        state_d = S_L;
      end
      S_L: begin
        l_d     = mul_p;
        state_d = S_M;
      end
      S_M: begin
        // A zero operand already produces 0 through the arithmetic, because
        // inv4(0) = 0. Forcing the result makes that explicit on the
        // SKIP_ZERO = 0 path.
        if (a_zero_q || b_zero_q) begin
          c_d = 8'h00;
        end else begin
          c_d = {h_q ^ e_w, l_q ^ e_w};
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (in_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered from the next state, so every output
    // comes straight from a flop.
    valid_d = (state_d == S_OUT);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q  <= IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 8'h00;
      dinv_q   <= 4'h0;
      i1_q     <= 4'h0;
      i0_q     <= 4'h0;
      h_q      <= 4'h0;
      l_q      <= 4'h0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      dinv_q   <= dinv_d;
      i1_q     <= i1_d;
      i0_q     <= i0_d;
      h_q      <= h_d;
      l_q      <= l_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign out_ready    = ready_q;
  assign out_valid    = valid_q;
  assign out_c        = c_q;
  assign out_div_zero = b_zero_q;

endmodule

// File: tb/tb_bv8_div_seq.sv
`timescale 1ns/1ps
module tb_bv8_div_seq;

  typedef logic [7:0] u8_t;

  typedef struct {
    u8_t   a;
    u8_t   b;
    bit    full;   // 1: SKIP_ZERO=0 instance, 0: SKIP_ZERO=1 instance
    u8_t   c;
    bit    dz;
    int    lat;
    string name;
  } vec_t;

  typedef struct {
    u8_t c;
    bit  dz;
  } exp_t;

  localparam int NVEC  = 8;
  localparam int NRAND = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic in_ready = 1'b1;
  logic valid_s = 1'b0;
  logic valid_f = 1'b0;

  logic s_ready, s_valid, s_dz;
  logic [7:0] s_c;
  logic f_ready, f_valid, f_dz;
  logic [7:0] f_c;

  int n_cmp = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_pop = 0;
  bit sb_on = 1'b0;
  exp_t sb_q[$];
  u8_t inv_tab[256];

  always #5 clk = ~clk;

  bv8_div_seq #(.SKIP_ZERO(1'b1)) dut_s (
    .in_clock(clk), .in_reset(rst), .in_valid(valid_s), .out_ready(s_ready),
    .in_a(a), .in_b(b), .out_valid(s_valid), .in_ready(in_ready),
    .out_c(s_c), .out_div_zero(s_dz)
  );

  bv8_div_seq #(.SKIP_ZERO(1'b0)) dut_f (
    .in_clock(clk), .in_reset(rst), .in_valid(valid_f), .out_ready(f_ready),
    .in_a(a), .in_b(b), .out_valid(f_valid), .in_ready(in_ready),
    .out_c(f_c), .out_div_zero(f_dz)
  );

  // ---------------- reference field model ----------------
  // GF(4) elements W^k: 11 = W^0, 01 = W^1, 10 = W^2. Multiply via exponents.
  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    int lx, ly, s;
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    lx = (x == 2'b11) ? 0 : (x == 2'b01) ? 1 : 2;
    ly = (y == 2'b11) ? 0 : (y == 2'b01) ? 1 : 2;
    s = (lx + ly) % 3;
    return (s == 0) ? 2'b11 : (s == 1) ? 2'b01 : 2'b10;
  endfunction

  // (aZ^4+bZ)(cZ^4+dZ), Z^2 = N^2 Z + N Z^4, Z*Z^4 = N, N = W^2.
  function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] ac, ad, bc, bd, hi, lo;
    ac = gf4_mul(x[3:2], y[3:2]);
    ad = gf4_mul(x[3:2], y[1:0]);
    bc = gf4_mul(x[1:0], y[3:2]);
    bd = gf4_mul(x[1:0], y[1:0]);
    hi = gf4_mul(2'b01, ac) ^ gf4_mul(2'b10, ad ^ bc ^ bd);
    lo = gf4_mul(2'b10, ac ^ ad ^ bc) ^ gf4_mul(2'b01, bd);
    return {hi, lo};
  endfunction

  // Y^2 + Y + nu = 0 with nu = N^2 Z = 4'h1.
  function automatic u8_t gf256_mul(input u8_t x, input u8_t y);
    logic [3:0] hh, hl, lh, ll, t;
    hh = gf16_mul(x[7:4], y[7:4]);
    hl = gf16_mul(x[7:4], y[3:0]);
    lh = gf16_mul(x[3:0], y[7:4]);
    ll = gf16_mul(x[3:0], y[3:0]);
    t  = gf16_mul(4'h1, hh ^ hl ^ lh ^ ll);
    return {hh ^ t, ll ^ t};
  endfunction

  function automatic exp_t model(input u8_t x, input u8_t y);
    exp_t r;
    if (y == 8'h00) begin
      r.c = 8'h00;
      r.dz = 1'b1;
    end else begin
      r.c = gf256_mul(x, inv_tab[y]);
      r.dz = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (sb_on) begin
      if (valid_s && s_ready) begin
        sb_q.push_back(model(a, b));
        n_push++;
      end
      if (s_valid && in_ready) begin : pop_blk
        exp_t e;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_extra: got c=%0h with no pending expectation, required none", s_c);
        end else begin
          e = sb_q.pop_front();
          check("sb_c", {24'h0, s_c}, {24'h0, e.c});
          check("sb_dz", {31'h0, s_dz}, {31'h0, e.dz});
          n_pop++;
          $display("sb txn %0d: c=%0h dz=%0b", n_pop, s_c, s_dz);
        end
      end
    end
  end

  // One complete operation with in_ready=1. Call at #1 after a rising edge.
  task automatic run_op(input bit full, input u8_t xa, input u8_t xb,
                        output u8_t c, output bit dz, output int lat);
    int guard;
    guard = 0;
    while (!(full ? f_ready : s_ready) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: out_ready got 0 after 50 cycles, required 1");
    end
    a = xa;
    b = xb;
    if (full) valid_f = 1'b1; else valid_s = 1'b1;
    @(posedge clk); #1;
    valid_f = 1'b0;
    valid_s = 1'b0;
    lat = 1;
    while (!(full ? f_valid : s_valid) && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    c  = full ? f_c : s_c;
    dz = full ? f_dz : s_dz;
    @(posedge clk); #1;   // handoff edge
  endtask

  vec_t vecs[NVEC];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    u8_t c, q, r, x, y;
    bit dz;
    int lat, guard, cycles, acc;

    // Inverse table by exhaustive search.
    inv_tab[0] = 8'h00;
    for (int i = 1; i < 256; i++) begin
      inv_tab[i] = 8'h00;
      for (int j = 1; j < 256; j++) begin
        if (gf256_mul(u8_t'(i), u8_t'(j)) == 8'hFF) begin
          inv_tab[i] = u8_t'(j);
          break;
        end
      end
    end

    vecs[0] = '{8'h5C, 8'hFF, 1'b0, 8'h5C, 1'b0, 7, "ident_skip"};
    vecs[1] = '{8'h5C, 8'hFF, 1'b1, 8'h5C, 1'b0, 7, "ident_full"};
    vecs[2] = '{8'h00, 8'h37, 1'b0, 8'h00, 1'b0, 1, "azero_skip"};
    vecs[3] = '{8'h37, 8'h00, 1'b0, 8'h00, 1'b1, 1, "bzero_skip"};
    vecs[4] = '{8'h00, 8'h37, 1'b1, 8'h00, 1'b0, 7, "azero_full"};
    vecs[5] = '{8'h37, 8'h00, 1'b1, 8'h00, 1'b1, 7, "bzero_full"};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 7, "one_one"};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1, "zero_zero"};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, s_valid}, 32'h0);
    check("rst_ready", {31'h0, s_ready}, 32'h1);
    check("rst_c", {24'h0, s_c}, 32'h0);
    check("rst_dz", {31'h0, s_dz}, 32'h0);
    check("rst_ready_f", {31'h0, f_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven directed vectors.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].full, vecs[i].a, vecs[i].b, c, dz, lat);
      $display("vec %s: a=%0h b=%0h c=%0h dz=%0b lat=%0d", vecs[i].name, vecs[i].a, vecs[i].b, c, dz, lat);
      check({vecs[i].name, "_c"}, {24'h0, c}, {24'h0, vecs[i].c});
      check({vecs[i].name, "_dz"}, {31'h0, dz}, {31'h0, vecs[i].dz});
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_rdy"}, {31'h0, vecs[i].full ? f_ready : s_ready}, 32'h1);
    end

    // Self-division over every nonzero b.
    for (int i = 1; i < 256; i++) begin
      run_op(1'b0, u8_t'(i), u8_t'(i), c, dz, lat);
      $display("selfdiv %0h/%0h: c=%0h", i, i, c);
      check("selfdiv", {24'h0, c}, 32'hFF);
    end

    // Round trip: a / (a / b) == b.
    for (int i = 0; i < 16; i++) begin
      x = u8_t'($urandom_range(1, 255));
      y = u8_t'($urandom_range(1, 255));
      run_op(1'b0, x, y, q, dz, lat);
      check("div_model", {24'h0, q}, {24'h0, model(x, y).c});
      run_op(1'b0, x, q, r, dz, lat);
      $display("roundtrip a=%0h b=%0h q=%0h back=%0h", x, y, q, r);
      check("div_back", {24'h0, r}, {24'h0, y});
    end

    // Backpressure in S_OUT.
    in_ready = 1'b0;
    a = 8'h5C;
    b = 8'hFF;
    valid_s = 1'b1;
    @(posedge clk); #1;
    valid_s = 1'b0;
    guard = 0;
    while (!s_valid && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      a = 8'h11;
      b = 8'h22;
      valid_s = 1'b1;
      check("bp_c", {24'h0, s_c}, 32'h5C);
      check("bp_ready", {31'h0, s_ready}, 32'h0);
      check("bp_valid", {31'h0, s_valid}, 32'h1);
      @(posedge clk); #1;
    end
    valid_s = 1'b0;
    in_ready = 1'b1;
    check("bp_c_hold", {24'h0, s_c}, 32'h5C);
    @(posedge clk); #1;
    $display("backpressure release: ready=%0b valid=%0b", s_ready, s_valid);
    check("bp_ready_rise", {31'h0, s_ready}, 32'h1);
    check("bp_valid_drop", {31'h0, s_valid}, 32'h0);
    @(posedge clk); #1;
    check("bp_no_ghost", {31'h0, s_valid}, 32'h0);

    // Reset during S_I0.
    a = 8'h12;
    b = 8'h34;
    valid_s = 1'b1;
    @(posedge clk); #1;     // now S_D
    valid_s = 1'b0;
    @(posedge clk); #1;     // S_I1
    @(posedge clk); #1;     // S_I0
    check("mid_busy", {31'h0, s_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("mid reset: valid=%0b c=%0h ready=%0b", s_valid, s_c, s_ready);
    check("mid_valid", {31'h0, s_valid}, 32'h0);
    check("mid_c", {24'h0, s_c}, 32'h0);
    check("mid_ready", {31'h0, s_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 8'h5C, 8'hFF, c, dz, lat);
    check("post_rst_c", {24'h0, c}, 32'h5C);
    check("post_rst_lat", lat, 7);

    // Random traffic with stalls, scored through the queue.
    sb_on = 1'b1;
    acc = 0;
    cycles = 0;
    while (acc < NRAND && cycles < 60000) begin
      x = u8_t'($urandom_range(0, 255));
      y = u8_t'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) x = 8'h00;
      if ($urandom_range(0, 15) == 0) y = 8'h00;
      a = x;
      b = y;
      valid_s = ($urandom_range(0, 3) != 0);
      in_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (valid_s && s_ready) acc++;
      @(posedge clk); #1;
      cycles++;
    end
    valid_s = 1'b0;
    in_ready = 1'b1;
    guard = 0;
    while ((sb_q.size() != 0 || s_valid) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    sb_on = 1'b0;
    check("sb_accepts", acc, NRAND);
    check("sb_drained", sb_q.size(), 0);
    check("sb_count", n_pop, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
